spart_tx_fifo: RTL
==================

Name: spart_tx_fifo

Overview:
- Parametrised next-generation SPART transmitter.
- Adds a TX FIFO, programmable data width and stop-bit count, an overflow flag, a busy indication, and optional parity.
- Sits between the SPART bus interface (iocs/iorw/ioaddr/databus) and the txd pin.
- Bit timing comes from the baud generator's one-cycle brg_full pulse: one pulse per bit period.

Parameters:
DATA_W, 8, data bits per frame, legal range 5..8, sent LSB first.
FIFO_DEPTH, 4, TX FIFO entries, power of two and at least 2.
STOP_BITS, 1, stop bits per frame, 1 or 2.

Ports:
clk  input  1  system clock.
rst  input  1  reset. One clock; reset is synchronous and active-low.
brg_full  input  1  baud tick, one-cycle pulse per bit period.
iocs  input  1  chip select.
iorw  input  1  1 = read, 0 = write.
ioaddr  input  2  register address.
databus  input  8  write data.
txd  output  1  serial line, idles high.
tbr  output  1  transmit buffer ready, 1 = FIFO not full.
tx_busy  output  1  1 while a frame is on the line.
fifo_count  output  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
ovf  output  1  sticky overflow flag.

Behaviour:
- Reset (rst=0 at posedge clk): txd=1, tbr=1, tx_busy=0, fifo_count=0, ovf=0, FSM=IDLE, FIFO pointers=0. Reset mid-frame aborts the frame; txd is 1 on the next cycle.
- Push: a write is iocs & ~iorw & ioaddr==0.
  - FIFO not full: databus[DATA_W-1:0] is pushed; fifo_count increments next cycle.
  - FIFO full: data is dropped and ovf is set next cycle.
- Clear: a write with ioaddr==1 and databus[0]=1 clears ovf. If a clear and an overflowing push occur in the same cycle, set wins.
- tbr is combinational: tbr = (fifo_count != FIFO_DEPTH).
- Pop and push in the same cycle: both take effect, fifo_count is unchanged. This is legal even when the FIFO is full, provided the pop is in that cycle.
- FSM, all transitions taken only on brg_full=1; the FSM holds otherwise:
  - IDLE: txd=1. If FIFO non-empty on brg_full: pop the head into the shift register, go to START. Pop and transition happen in the same cycle.
  - START: txd=0. On brg_full go to DATA with bit index=0.
  - DATA: txd=shift[0]. On brg_full shift right and increment the index. After bit DATA_W-1 go to PARITY if enabled, else STOP.
  - PARITY: txd=parity bit. On brg_full go to STOP.
  - STOP: txd=1. Lasts STOP_BITS brg_full periods, then goes to IDLE.
    - If the FIFO is non-empty at the final stop tick, pop and go straight to START. Frames are then back-to-back with no idle period.
- txd is driven from a register, so it changes one cycle after the qualifying brg_full edge.
- tx_busy=1 in every state except IDLE.
- Frame length = 1 + DATA_W + parity(0/1) + STOP_BITS ticks.
- Writes to ioaddr 2 and 3, and all reads, are ignored.
- Counters:
  - The bit index is $clog2(DATA_W) wide.
  - The stop counter is 1 bit.
  - FIFO pointers wrap modulo FIFO_DEPTH.
  - fifo_count saturates at 0 and FIFO_DEPTH and never wraps.

Optional Feature:
- Macro: SPART_TX_PARITY_EN.
- Defined:
  - Adds the PARITY state and a 2-bit parity mode register, written via ioaddr==2 from databus[1:0]. The register resets to 0.
  - Modes: 00 = no parity, PARITY skipped. 01 = even: parity bit = XOR of the data bits. 10 = odd: the inverse of even. 11 = mark: always 1.
  - The mode is sampled at the IDLE-to-START pop, so a mid-frame change does not affect the current frame.
- Undefined:
  - The PARITY state and mode register are absent, and writes to ioaddr 2 are ignored.
  - Frame is always 1 + DATA_W + STOP_BITS ticks.

Test Plan:
- Reset: hold rst=0 for 3 cycles with brg_full toggling -> txd=1, tbr=1, fifo_count=0, ovf=0, tx_busy=0.
- Single frame: DATA_W=8, STOP_BITS=1, push 0xA5, brg_full every 16 cycles.
  - txd sequence per tick: 0,1,0,1,0,0,1,0,1,1.
  - tx_busy drops after the 10th tick.
- Back-to-back: push 0x01, 0x02, 0x03 on consecutive cycles -> three contiguous frames with no idle tick between them; fifo_count goes 1,2,3, then decrements at each IDLE/STOP pop.
- Overflow: FIFO_DEPTH=4, hold brg_full=0 and push 5 bytes.
  - tbr=0 after the 4th push; ovf=1 after the 5th.
  - The 5th byte never appears on txd.
  - Writing ioaddr=1 with data 0x01 clears ovf.
- Reset mid-frame: assert rst=0 during DATA bit 3 -> txd=1 next cycle, FIFO empty, no remnant bits after release.
- Parity (SPART_TX_PARITY_EN): mode=01, push 0x07 -> parity bit 1. Mode=10 -> parity bit 0. STOP_BITS=2 -> two high ticks before the next start bit.

Source files
------------

// File: rtl/spart_tx_fifo.sv
// SPART transmitter with TX FIFO, programmable width and stop bits, sticky overflow.
// Define SPART_TX_PARITY_EN to add the parity mode register (ioaddr 2) and PARITY state.
module spart_tx_fifo #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int STOP_BITS  = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          brg_full,
    input  logic                          iocs,
    input  logic                          iorw,
    input  logic [1:0]                    ioaddr,
    input  logic [7:0]                    databus,
    output logic                          txd,
    output logic                          tbr,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          ovf
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int BW = $clog2(DATA_W);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

`ifdef SPART_TX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    state_t              r_state;
    state_t              w_state_nxt;
    logic [DATA_W-1:0]   r_shift;
    logic [DATA_W-1:0]   w_shift_nxt;
    logic [BW-1:0]       r_bit;
    logic [BW-1:0]       w_bit_nxt;
    logic                r_stop;
    logic                w_stop_nxt;
    logic                r_txd;
    logic                w_txd_nxt;

    logic [DATA_W-1:0]   r_mem [FIFO_DEPTH];
    logic [PW-1:0]       r_wptr;
    logic [PW-1:0]       r_rptr;
    logic [CW-1:0]       r_count;
    logic                r_ovf;

    logic                w_wr;
    logic                w_push_req;
    logic                w_push;
    logic                w_pop;
    logic                w_load;
    logic                w_full;
    logic                w_nempty;
    logic                w_ovf_set;
    logic                w_ovf_clr;
    logic [DATA_W-1:0]   w_head;

`ifdef SPART_TX_PARITY_EN
    logic [1:0]          r_par_mode;
    logic                r_par_on;
    logic                r_par_bit;
`endif

    assign w_wr       = iocs & ~iorw;
    assign w_push_req = w_wr & (ioaddr == 2'd0);
    assign w_full     = (r_count == FULL_CNT);
    assign w_nempty   = (r_count != '0);
    assign w_head     = r_mem[r_rptr];
    // A pop in the same cycle frees a slot, so a push to a full FIFO still lands
    assign w_push     = w_push_req & (~w_full | w_pop);
    assign w_ovf_set  = w_push_req & w_full & ~w_pop;
    assign w_ovf_clr  = w_wr & (ioaddr == 2'd1) & databus[0];

    assign txd        = r_txd;
    assign tbr        = ~w_full;
    assign tx_busy    = (r_state != S_IDLE);
    assign fifo_count = r_count;
    assign ovf        = r_ovf;

    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_bit_nxt   = r_bit;
        w_stop_nxt  = r_stop;
        w_pop       = 1'b0;
        w_load      = 1'b0;
        if (brg_full) begin
            case (r_state)
                S_IDLE: begin
                    if (w_nempty) begin
                        w_pop       = 1'b1;
                        w_load      = 1'b1;
                        w_state_nxt = S_START;
                    end
                end
                S_START: begin
                    w_state_nxt = S_DATA;
                    w_bit_nxt   = '0;
                end
                S_DATA: begin
                    w_shift_nxt = r_shift >> 1;
                    w_bit_nxt   = r_bit + BW'(1);
                    if (r_bit == LAST_BIT) begin
                        w_stop_nxt  = 1'b0;
`ifdef SPART_TX_PARITY_EN
                        w_state_nxt = r_par_on ? S_PARITY : S_STOP;
`else
                        w_state_nxt = S_STOP;
`endif
                    end
                end
`ifdef SPART_TX_PARITY_EN
                S_PARITY: begin
                    w_state_nxt = S_STOP;
                    w_stop_nxt  = 1'b0;
                end
`endif
                S_STOP: begin
                    if (STOP_BITS == 1 || r_stop) begin
                        // Chain straight into the next frame when data is waiting
                        if (w_nempty) begin
                            w_pop       = 1'b1;
                            w_load      = 1'b1;
                            w_state_nxt = S_START;
                        end else begin
                            w_state_nxt = S_IDLE;
                        end
                    end else begin
                        w_stop_nxt = 1'b1;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
        if (w_load) begin
            w_shift_nxt = w_head;
        end
    end

    always_comb begin
        w_txd_nxt = 1'b1;
        case (w_state_nxt)
            S_START:  w_txd_nxt = 1'b0;
            S_DATA:   w_txd_nxt = w_shift_nxt[0];
`ifdef SPART_TX_PARITY_EN
            S_PARITY: w_txd_nxt = r_par_bit;
`endif
            default:  w_txd_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_shift <= '0;
            r_bit   <= '0;
            r_stop  <= 1'b0;
            r_txd   <= 1'b1;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_shift <= w_shift_nxt;
            r_bit   <= w_bit_nxt;
            r_stop  <= w_stop_nxt;
            r_txd   <= w_txd_nxt;
            if (w_push) begin
                r_wptr <= r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end else if (w_ovf_clr) begin
                r_ovf <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= databus[DATA_W-1:0];
        end
    end

`ifdef SPART_TX_PARITY_EN
    // Mode is latched with the frame so mid-frame writes only affect later frames
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_par_mode <= 2'b00;
            r_par_on   <= 1'b0;
            r_par_bit  <= 1'b0;
        end else begin
            if (w_wr && ioaddr == 2'd2) begin
                r_par_mode <= databus[1:0];
            end
            if (w_load) begin
                r_par_on <= (r_par_mode != 2'b00);
                case (r_par_mode)
                    2'b01:   r_par_bit <= ^w_head;
                    2'b10:   r_par_bit <= ~^w_head;
                    default: r_par_bit <= 1'b1;
                endcase
            end
        end
    end
`endif

endmodule
